// File: rtl/wish_packer_pkg.sv
// Shared tag-bit positions and lane placement helper for the stream packer.
package wish_packer_pkg;
  localparam int TGC_FIRST_BIT = 0;
  localparam int TGC_LAST_BIT  = 1;

  // Bit offset of the lane written by beat number idx within a packed word.
  function automatic int lane_offset(input int idx, input int num_pack,
                                     input int data_width, input bit little_endian);
    return little_endian ? idx * data_width : (num_pack - 1 - idx) * data_width;
  endfunction
endpackage

// File: rtl/wish_packer.sv
// Packs NUM_PACK narrow Wishbone-style stream beats into one wide word;
// a last-of-frame tag flushes a partial word with unwritten lanes zero.
module wish_packer
  import wish_packer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter int LITTLE_ENDIAN = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_cyc_i,
  input  logic                           s_stb_i,
  input  logic [DATA_WIDTH-1:0]          s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  output logic                           d_cyc_o,
  output logic                           d_stb_o,
  output logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o,
  input  logic                           d_ack_i
);
  localparam int W  = DATA_WIDTH * NUM_PACK;
  localparam int IW = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_PACK - 1);

  logic [IW-1:0] idx;
  logic [W-1:0]  acc, merged;
  logic          first_q;
  logic          accept, complete, grp_first;
  int            off;

  // Stall only while an unacknowledged word is held, so a completing beat
  // can never overwrite a word the sink has not taken.
  assign s_stall_o = d_stb_o & ~d_ack_i;
  assign accept    = s_cyc_i & s_stb_i & ~s_stall_o;
  assign complete  = accept & ((idx == IDX_LAST) | s_tgc_i[TGC_LAST_BIT]);
  assign grp_first = (idx == '0) ? s_tgc_i[TGC_FIRST_BIT] : first_q;
  assign d_cyc_o   = d_stb_o;
  assign off       = lane_offset(int'(idx), NUM_PACK, DATA_WIDTH, LITTLE_ENDIAN != 0);

  always_comb begin
    merged = acc;
    merged[off +: DATA_WIDTH] = s_dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx     <= '0;
      acc     <= '0;
      first_q <= 1'b0;
      s_ack_o <= 1'b0;
      d_stb_o <= 1'b0;
      d_dat_o <= '0;
      d_tgc_o <= '0;
    end else begin
      s_ack_o <= accept;
      if (complete) begin
        d_dat_o <= merged;
        d_tgc_o <= {s_tgc_i[TGC_WIDTH-1:TGC_LAST_BIT], grp_first};
        d_stb_o <= 1'b1;
        idx     <= '0;
        acc     <= '0;
      end else begin
        if (d_ack_i) d_stb_o <= 1'b0;
        if (accept) begin
          acc <= merged;
          idx <= idx + IW'(1);
          if (idx == '0) first_q <= s_tgc_i[TGC_FIRST_BIT];
        end
      end
    end
  end
endmodule

// File: tb/tb_wish_packer.sv
// Directed table-driven bench for wish_packer: big- and little-endian
// instances share stimulus; hand sequences cover backpressure and reset.
module tb_wish_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, ack;
  logic [7:0]  dat;
  logic [1:0]  tgc;
  logic        be_sack, be_stall, be_dcyc, be_dstb;
  logic [31:0] be_ddat;
  logic [1:0]  be_dtgc;
  logic        le_sack, le_stall, le_dcyc, le_dstb;
  logic [31:0] le_ddat;
  logic [1:0]  le_dtgc;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  wish_packer #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(0)) dut_be (
    .clk_i(clk), .rst_i(rst), .s_cyc_i(cyc), .s_stb_i(stb), .s_dat_i(dat), .s_tgc_i(tgc),
    .s_ack_o(be_sack), .s_stall_o(be_stall), .d_cyc_o(be_dcyc), .d_stb_o(be_dstb),
    .d_dat_o(be_ddat), .d_tgc_o(be_dtgc), .d_ack_i(ack));

  wish_packer #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1)) dut_le (
    .clk_i(clk), .rst_i(rst), .s_cyc_i(cyc), .s_stb_i(stb), .s_dat_i(dat), .s_tgc_i(tgc),
    .s_ack_o(le_sack), .s_stall_o(le_stall), .d_cyc_o(le_dcyc), .d_stb_o(le_dstb),
    .d_dat_o(le_ddat), .d_tgc_o(le_dtgc), .d_ack_i(ack));

  typedef struct {
    logic        cyc, stb;
    logic [7:0]  dat;
    logic [1:0]  tgc;
    logic        ack;
    logic        x_stall, x_sack, x_stb;
    logic [31:0] x_be, x_le;
    logic [1:0]  x_tgc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic c, logic s, logic [7:0] d, logic [1:0] t,
                              logic sack, logic dstb, logic [31:0] xbe, logic [31:0] xle,
                              logic [1:0] xt);
    vec_t v;
    v.cyc = c; v.stb = s; v.dat = d; v.tgc = t; v.ack = 1'b1; v.x_stall = 1'b0;
    v.x_sack = sack; v.x_stb = dstb; v.x_be = xbe; v.x_le = xle; v.x_tgc = xt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic [7:0] d,
                       input logic [1:0] t, input logic a);
    @(negedge clk);
    cyc = c; stb = s; dat = d; tgc = t; ack = a;
    #1;
  endtask

  task automatic post(input string tag, input logic sack, input logic dstb,
                      input logic [31:0] xbe, input logic [1:0] xt);
    @(posedge clk);
    #1;
    chk({tag, ".s_ack"}, 32'(be_sack), 32'(sack));
    chk({tag, ".d_stb"}, 32'(be_dstb), 32'(dstb));
    chk({tag, ".d_cyc"}, 32'(be_dcyc), 32'(dstb));
    chk({tag, ".d_dat"}, be_ddat, xbe);
    chk({tag, ".d_tgc"}, 32'(be_dtgc), 32'(xt));
  endtask

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; dat = 0; tgc = 0; ack = 1;
    // big-endian / little-endian full group
    vt.push_back(mk(1,1,8'h11,2'b01, 1,0,32'h0,32'h0,2'b00));
    vt.push_back(mk(1,1,8'h22,2'b00, 1,0,32'h0,32'h0,2'b00));
    vt.push_back(mk(1,1,8'h33,2'b00, 1,0,32'h0,32'h0,2'b00));
    vt.push_back(mk(1,1,8'h44,2'b00, 1,1,32'h11223344,32'h44332211,2'b01));
    vt.push_back(mk(0,0,8'h00,2'b00, 0,0,32'h11223344,32'h44332211,2'b01));
    // partial flush
    vt.push_back(mk(1,1,8'hAA,2'b01, 1,0,32'h11223344,32'h44332211,2'b01));
    vt.push_back(mk(1,1,8'hBB,2'b10, 1,1,32'hAABB0000,32'h0000BBAA,2'b11));
    vt.push_back(mk(0,0,8'h00,2'b00, 0,0,32'hAABB0000,32'h0000BBAA,2'b11));
    // back-to-back 12 beats
    vt.push_back(mk(1,1,8'h01,2'b01, 1,0,32'hAABB0000,32'h0000BBAA,2'b11));
    vt.push_back(mk(1,1,8'h02,2'b00, 1,0,32'hAABB0000,32'h0000BBAA,2'b11));
    vt.push_back(mk(1,1,8'h03,2'b00, 1,0,32'hAABB0000,32'h0000BBAA,2'b11));
    vt.push_back(mk(1,1,8'h04,2'b00, 1,1,32'h01020304,32'h04030201,2'b01));
    vt.push_back(mk(1,1,8'h05,2'b01, 1,0,32'h01020304,32'h04030201,2'b01));
    vt.push_back(mk(1,1,8'h06,2'b00, 1,0,32'h01020304,32'h04030201,2'b01));
    vt.push_back(mk(1,1,8'h07,2'b00, 1,0,32'h01020304,32'h04030201,2'b01));
    vt.push_back(mk(1,1,8'h08,2'b00, 1,1,32'h05060708,32'h08070605,2'b01));
    vt.push_back(mk(1,1,8'h09,2'b01, 1,0,32'h05060708,32'h08070605,2'b01));
    vt.push_back(mk(1,1,8'h0A,2'b00, 1,0,32'h05060708,32'h08070605,2'b01));
    vt.push_back(mk(1,1,8'h0B,2'b00, 1,0,32'h05060708,32'h08070605,2'b01));
    vt.push_back(mk(1,1,8'h0C,2'b00, 1,1,32'h090A0B0C,32'h0C0B0A09,2'b01));
    // source idle mid-group, strobe without cycle, first flag mid-group
    vt.push_back(mk(1,1,8'hD1,2'b00, 1,0,32'h090A0B0C,32'h0C0B0A09,2'b01));
    vt.push_back(mk(1,1,8'hD2,2'b00, 1,0,32'h090A0B0C,32'h0C0B0A09,2'b01));
    vt.push_back(mk(0,0,8'h00,2'b00, 0,0,32'h090A0B0C,32'h0C0B0A09,2'b01));
    vt.push_back(mk(0,1,8'hEE,2'b10, 0,0,32'h090A0B0C,32'h0C0B0A09,2'b01));
    vt.push_back(mk(1,1,8'hD3,2'b01, 1,0,32'h090A0B0C,32'h0C0B0A09,2'b01));
    vt.push_back(mk(1,1,8'hD4,2'b00, 1,1,32'hD1D2D3D4,32'hD4D3D2D1,2'b00));
    vt.push_back(mk(0,0,8'h00,2'b00, 0,0,32'hD1D2D3D4,32'hD4D3D2D1,2'b00));

    #2;
    chk("rst.s_ack", 32'(be_sack), 0);
    chk("rst.s_stall", 32'(be_stall), 0);
    chk("rst.d_stb", 32'(be_dstb), 0);
    chk("rst.d_dat", be_ddat, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].cyc, vt[i].stb, vt[i].dat, vt[i].tgc, vt[i].ack);
      chk($sformatf("v%0d.stall", i), 32'(be_stall), 32'(vt[i].x_stall));
      post($sformatf("v%0d", i), vt[i].x_sack, vt[i].x_stb, vt[i].x_be, vt[i].x_tgc);
      chk($sformatf("v%0d.le_dat", i), le_ddat, vt[i].x_le);
      chk($sformatf("v%0d.le_stb", i), 32'(le_dstb), 32'(vt[i].x_stb));
    end

    // backpressure: first word held, beat 0x55 stalled, nothing lost
    drive(1,1,8'h11,2'b01,0); post("bp0", 1,0,32'hD1D2D3D4,2'b00);
    drive(1,1,8'h22,2'b00,0); post("bp1", 1,0,32'hD1D2D3D4,2'b00);
    drive(1,1,8'h33,2'b00,0); post("bp2", 1,0,32'hD1D2D3D4,2'b00);
    drive(1,1,8'h44,2'b00,0); post("bp3", 1,1,32'h11223344,2'b01);
    for (int k = 0; k < 4; k++) begin
      drive(1,1,8'h55,2'b01,0);
      chk($sformatf("bp_hold%0d.stall", k), 32'(be_stall), 1);
      post($sformatf("bp_hold%0d", k), 0,1,32'h11223344,2'b01);
    end
    drive(1,1,8'h55,2'b01,1);
    chk("bp_rel.stall", 32'(be_stall), 0);
    post("bp_rel", 1,0,32'h11223344,2'b01);
    drive(1,1,8'h66,2'b00,1); post("bp6", 1,0,32'h11223344,2'b01);
    drive(1,1,8'h77,2'b00,1); post("bp7", 1,0,32'h11223344,2'b01);
    drive(1,1,8'h88,2'b00,0); post("bp8", 1,1,32'h55667788,2'b01);
    drive(0,0,8'h00,2'b00,0);
    chk("bp9.stall", 32'(be_stall), 1);
    post("bp9", 0,1,32'h55667788,2'b01);
    drive(0,0,8'h00,2'b00,1); post("bp10", 0,0,32'h55667788,2'b01);

    // reset mid-group discards partial beats and the held word
    drive(1,1,8'hA1,2'b01,1); post("rm0", 1,0,32'h55667788,2'b01);
    drive(1,1,8'hA2,2'b00,1); post("rm1", 1,0,32'h55667788,2'b01);
    @(negedge clk);
    cyc = 0; stb = 0; rst = 1'b1;
    #1;
    chk("rm.s_ack", 32'(be_sack), 0);
    chk("rm.d_stb", 32'(be_dstb), 0);
    chk("rm.d_dat", be_ddat, 0);
    chk("rm.d_tgc", 32'(be_dtgc), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1,1,8'hB1,2'b01,1); post("rb0", 1,0,32'h0,2'b00);
    drive(1,1,8'hB2,2'b00,1); post("rb1", 1,0,32'h0,2'b00);
    drive(1,1,8'hB3,2'b00,1); post("rb2", 1,0,32'h0,2'b00);
    drive(1,1,8'hB4,2'b00,1); post("rb3", 1,1,32'hB1B2B3B4,2'b01);
    chk("rb3.le_dat", le_ddat, 32'hB4B3B2B1);
    drive(0,0,8'h00,2'b00,1); post("rb4", 0,0,32'hB1B2B3B4,2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wish_packer.md
Name: wish_packer

Overview:
- Wishbone-style stream width converter that packs NUM_PACK consecutive DATA_WIDTH-wide input beats into one (DATA_WIDTH*NUM_PACK)-wide output word.
- It sits between a narrow stream source (for example a file-reader stimulus master) and a wide stream sink (for example a file-writer logger slave).
- Packing is frame-aware: a beat flagged "last" in its tag flushes a partial word.

Parameters:
- DATA_WIDTH, 8, width of one input beat in bits.
- NUM_PACK, 4, number of input beats per output word; must be at least 2.
- TGC_WIDTH, 2, cycle-tag width; must be at least 2. Bit 0 is first-of-frame, bit 1 is last-of-frame, bits above 1 are user bits.
- LITTLE_ENDIAN, 0, lane order. 0: first beat goes to the most-significant lane. 1: first beat goes to lane 0, bits DATA_WIDTH-1:0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- s_cyc_i  in  1  source cycle valid.
- s_stb_i  in  1  source strobe; a beat is offered when this and s_cyc_i are both high.
- s_dat_i  in  DATA_WIDTH  source beat data.
- s_tgc_i  in  TGC_WIDTH  source beat tag.
- s_ack_o  out  1  acknowledge, registered, one cycle after acceptance.
- s_stall_o  out  1  pipelined stall; the offered beat is not accepted while this is high.
- d_cyc_o  out  1  destination cycle valid; always equal to d_stb_o.
- d_stb_o  out  1  packed word valid.
- d_dat_o  out  DATA_WIDTH*NUM_PACK  packed word.
- d_tgc_o  out  TGC_WIDTH  packed word tag.
- d_ack_i  in  1  destination acknowledge; the word transfers when d_stb_o and d_ack_i are both high.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high. While reset is asserted, every output is 0, the lane count is 0 and the accumulator is 0.
- Acceptance: a beat is accepted on a rising edge where s_cyc_i, s_stb_i and !s_stall_o are all high.
- s_ack_o equals the registered acceptance, so it is high for exactly one cycle per accepted beat, in the cycle after acceptance.
- s_stall_o equals d_stb_o && !d_ack_i, computed combinationally. Any beat may be accepted in the same cycle the held word is acknowledged.
- Lane placement: the lane count idx runs 0..NUM_PACK-1.
  - LITTLE_ENDIAN=0: the beat at index idx is written to bits [(NUM_PACK-idx)*DATA_WIDTH-1 -: DATA_WIDTH].
  - LITTLE_ENDIAN=1: the beat at index idx is written to bits [idx*DATA_WIDTH +: DATA_WIDTH].
- Group completion: a group completes on an accepted beat when idx==NUM_PACK-1 or s_tgc_i[1]==1.
  - On completion, the accumulator merged with the current beat is loaded into the output register on the same edge.
  - d_stb_o rises in the next cycle, giving zero extra latency after the completing beat.
  - idx returns to 0 and the accumulator clears to 0.
  - Otherwise, on acceptance, idx increments.
- Partial flush: lanes not written in a flushed partial word are 0.
- Output tag:
  - d_tgc_o[0] is the bit-0 tag of the group's first beat.
  - d_tgc_o[1] and all higher bits are the tag of the completing beat.
- Output hold: d_dat_o, d_tgc_o and d_stb_o stay stable until d_ack_i.
  - On an ack with no new completion, d_stb_o falls.
  - On an ack coinciding with a completion, the new word loads and d_stb_o stays high, sustaining one word per NUM_PACK cycles.
- Throughput: one input beat per cycle while the destination keeps up.
- A first-flag appearing mid-group is carried through only as data; it does not realign the group.
- Source idle: if s_cyc_i drops mid-group, the partial group is retained until more beats arrive.
- Reset mid-operation discards the partial group and the held word. s_ack_o is not issued for a beat whose acceptance edge coincides with reset.

Decomposition:
- A shared package holds TGC_FIRST_BIT=0, TGC_LAST_BIT=1, and a function returning a lane's bit offset from idx, NUM_PACK, DATA_WIDTH and LITTLE_ENDIAN.
- No sub-module is required; the block is a single flat module with accumulator, counter and output register.

Test Plan:
- Big-endian group: DATA_WIDTH=8, NUM_PACK=4, LITTLE_ENDIAN=0, d_ack_i=1. Beats 0x11,0x22,0x33,0x44 with tgc 01,00,00,00 -> d_dat_o=0x11223344, d_tgc_o=01, d_stb_o high for 1 cycle, four s_ack_o pulses.
- Little-endian group: same beats with LITTLE_ENDIAN=1 -> d_dat_o=0x44332211.
- Partial flush: beats 0xAA with tgc 01, then 0xBB with tgc 10, LITTLE_ENDIAN=0 -> d_dat_o=0xAABB0000, d_tgc_o=11, idx=0 afterwards.
- Backpressure: hold d_ack_i=0 after the first word, with 8 beats offered -> s_stall_o high while d_stb_o is high and d_ack_i=0. The first word is held stable. No beat is lost; the second word is 0x55667788 for input 0x55..0x88 once d_ack_i=1.
- Back-to-back: 12 contiguous beats with d_ack_i=1 -> 3 words on consecutive group boundaries, no stall.
- Reset mid-group: assert rst_i after 2 beats -> all outputs 0 immediately. The next 4 beats after release form a complete word with no residue.
